multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle CPU. Decodes the 4-bit opcode, sequences fetch/decode/execute/memory/writeback over several clock cycles, and drives every datapath select and write enable. For R-type instructions it drives `ALUop` to 3'b000 so the ALU control stage decodes the function field. It waits on a memory ready handshake, so memory latency is variable.

---
 rtl/multicycle_controller_pkg.sv | 81 ++++++++
 rtl/multicycle_controller_if.sv | 51 +++++
 rtl/multicycle_controller_out_decode.sv | 90 +++++++++
 rtl/multicycle_controller.sv | 122 ++++++++++++
 tb/tb_multicycle_controller.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and codes for the multi-cycle CPU control FSM.
// HALT exists only when ILLEGAL_TRAP_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
`ifdef ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_SUBI  = 4'h2;
  localparam logic [3:0] OP_ANDI  = 4'h3;
  localparam logic [3:0] OP_ORI   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_BEQZ  = 4'h8;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_OR    = 3'b111;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_OFF  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       instr_done;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_BEQZ;
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
    case (op)
      OP_SUBI: return ALU_SUB;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory control bundle. `illegal` exists only with
// ILLEGAL_TRAP_EN. master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;

  // Handshake: the controller holds MemRead/MemWrite and the address select
  // steady while waiting; memory raises mem_ready for exactly the cycle in
  // which the access completes, and the controller advances on that edge.
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUop;
  logic       instr_done;
  logic       mem_timeout;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSrc, ALUop,
           instr_done, mem_timeout
`ifdef ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSrc, ALUop,
           instr_done, mem_timeout
`ifdef ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

endinterface

// File: rtl/multicycle_controller_out_decode.sv
// Combinational state-to-control decode for the multi-cycle controller.
// ILLEGAL_TRAP_EN selects HALT decode versus the illegal-opcode NOP pulse.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_op,
  input  logic [3:0] i_opcode,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_ONE;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_OFF;
        o_ctrl.alu_op    = ALU_ADD;
`ifndef ILLEGAL_TRAP_EN
        // An illegal opcode retires here as a NOP.
        o_ctrl.instr_done = !is_legal(i_opcode);
`endif
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_WB_R: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = imm_alu_op(i_op);
      end
      S_WB_I: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.ior_d      = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_src     = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: o_ctrl.illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle CPU: sequencing, memory wait counter
// and sticky timeout. ILLEGAL_TRAP_EN enables the HALT trap on bad opcodes.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master io_bus,
  output state_t                  o_dbg_state
);

  localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_WAIT_MAX);
  localparam bit WAIT_EN = (MEM_WAIT_MAX != 0);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_op;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_timeout;
  logic          w_wait;
  ctrl_t         w_ctrl;
  ctrl_t         w_ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // The opcode is only meaningful while the IR is freshly loaded (DECODE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_op <= OP_RTYPE;
    else if (r_state == S_DECODE) r_op <= io_bus.opcode;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: if (io_bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (io_bus.opcode)
          OP_RTYPE:                            w_next = S_EXEC_R;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI:   w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:                   w_next = S_MEM_ADDR;
          OP_BEQZ:                             w_next = S_BRANCH;
          OP_JUMP:                             w_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:                             w_next = S_HALT;
`else
          default:                             w_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_WB_R:     w_next = S_FETCH;
      S_EXEC_I:   w_next = S_WB_I;
      S_WB_I:     w_next = S_FETCH;
      S_MEM_ADDR: w_next = (r_op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (io_bus.mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (io_bus.mem_ready) w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:     w_next = S_HALT;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // A wait cycle never changes state, so clearing on every non-wait cycle
  // also covers the clear-on-state-change rule.
  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                   (r_state == S_MEM_WR)) && !io_bus.mem_ready;
  assign w_cnt_nxt = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait ? w_cnt_nxt : '0;
      if (WAIT_EN && w_wait && (w_cnt_nxt == CNT_MAX)) r_timeout <= 1'b1;
    end
  end

  mc_out_decode u_out_decode (
    .i_state     (r_state),
    .i_op        (r_op),
    .i_opcode    (io_bus.opcode),
    .i_mem_ready (io_bus.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Reset blanks the controls immediately, not only after the next edge.
  assign w_ctrl_q = rst ? '0 : w_ctrl;

  assign io_bus.PCWrite     = w_ctrl_q.pc_write;
  assign io_bus.PCWriteCond = w_ctrl_q.pc_write_cond;
  assign io_bus.IorD        = w_ctrl_q.ior_d;
  assign io_bus.MemRead     = w_ctrl_q.mem_read;
  assign io_bus.MemWrite    = w_ctrl_q.mem_write;
  assign io_bus.IRWrite     = w_ctrl_q.ir_write;
  assign io_bus.RegWrite    = w_ctrl_q.reg_write;
  assign io_bus.MemtoReg    = w_ctrl_q.mem_to_reg;
  assign io_bus.RegDst      = w_ctrl_q.reg_dst;
  assign io_bus.ALUSrcA     = w_ctrl_q.alu_src_a;
  assign io_bus.ALUSrcB     = w_ctrl_q.alu_src_b;
  assign io_bus.PCSrc       = w_ctrl_q.pc_src;
  assign io_bus.ALUop       = w_ctrl_q.alu_op;
  assign io_bus.instr_done  = w_ctrl_q.instr_done;
  assign io_bus.mem_timeout = r_timeout;
`ifdef ILLEGAL_TRAP_EN
  assign io_bus.illegal     = w_ctrl_q.illegal;
`endif

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model
// expands each opcode into its expected per-cycle control words.
module tb_multicycle_controller;
  import mc_pkg::*;

  localparam int WAIT_MAX = 4;

  localparam logic [9:0] B_PCW  = 10'b1000000000;
  localparam logic [9:0] B_PCWC = 10'b0100000000;
  localparam logic [9:0] B_IORD = 10'b0010000000;
  localparam logic [9:0] B_MR   = 10'b0001000000;
  localparam logic [9:0] B_MW   = 10'b0000100000;
  localparam logic [9:0] B_IRW  = 10'b0000010000;
  localparam logic [9:0] B_RW   = 10'b0000001000;
  localparam logic [9:0] B_M2R  = 10'b0000000100;
  localparam logic [9:0] B_RD   = 10'b0000000010;
  localparam logic [9:0] B_ASA  = 10'b0000000001;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  multicycle_controller_if bus();

  multicycle_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- observation ----------------
  logic ill_obs;
`ifdef ILLEGAL_TRAP_EN
  assign ill_obs = bus.illegal;
`else
  assign ill_obs = 1'b0;
`endif
  logic [19:0] got_w;
  assign got_w = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.MemtoReg,
                  bus.RegDst, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUop,
                  bus.instr_done, bus.mem_timeout, ill_obs};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];
  logic        rdy_q[$];
  logic [3:0]  op_q[$];
  bit          wait_q[$];
  string       tag_q[$];
  bit          aligned   = 0;
  int          m_run     = 0;
  bit          m_timeout = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] w(input logic [9:0] f, input logic [1:0] asb,
                                    input logic [1:0] pcs, input logic [2:0] aop,
                                    input logic done, input logic ill);
    return {f, asb, pcs, aop, done, 1'b0, ill};
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic [19:0] e, input logic rdy, input logic [3:0] op,
                      input bit wt, input string tag);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    op_q.push_back(op);
    wait_q.push_back(wt);
    tag_q.push_back(tag);
  endtask

  task automatic step();
    logic [19:0] e;
    bit wt;
    string t;
    if (!aligned) begin
      @(posedge clk);
      #1;
    end
    aligned = 0;
    e  = exp_q.pop_front();
    wt = wait_q.pop_front();
    t  = tag_q.pop_front();
    bus.mem_ready = rdy_q.pop_front();
    bus.opcode    = op_q.pop_front();
    bus.zero      = rnd1();
    #3;
    e[1] = m_timeout;
    check(t, 32'(got_w), 32'(e));
    if (wt) begin
      m_run++;
      if (m_run >= WAIT_MAX) m_timeout = 1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic exec_queue(input int abort_after);
    int n = 0;
    while (exp_q.size() > 0) begin
      if (abort_after >= 0 && n == abort_after) begin
        exp_q.delete(); rdy_q.delete(); op_q.delete();
        wait_q.delete(); tag_q.delete();
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (!aligned) begin
        @(posedge clk);
        #1;
      end
      aligned = 0;
      rst = 1'b1;
      bus.mem_ready = rnd1();
      bus.opcode    = rnd4();
      #3;
      check("rst_outputs", 32'(got_w), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(S_FETCH));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    aligned = 1;
    m_run = 0;
    m_timeout = 0;
  endtask

  // Expands one instruction into expected cycles, then runs them.
  task automatic run_instr(input logic [3:0] op, input int wf, input int wm,
                           input int abort_after);
    bit legal = (op <= 4'd8);
    logic done_dec;
`ifdef ILLEGAL_TRAP_EN
    done_dec = 1'b0;
`else
    done_dec = !legal;
`endif
    for (int i = 0; i < wf; i++)
      push(w(B_MR, 2'b01, 2'b00, 3'b100, 0, 0), 1'b0, rnd4(), 1, "fetch_wait");
    push(w(B_MR | B_IRW | B_PCW, 2'b01, 2'b00, 3'b100, 0, 0), 1'b1, rnd4(), 0, "fetch");
    push(w(10'd0, 2'b11, 2'b00, 3'b100, done_dec, 0), rnd1(), op, 0, "decode");
    if (op == 4'd0) begin
      push(w(B_ASA, 2'b00, 2'b00, 3'b000, 0, 0), rnd1(), rnd4(), 0, "exec_r");
      push(w(B_RW | B_RD, 2'b00, 2'b00, 3'b000, 1, 0), rnd1(), rnd4(), 0, "wb_r");
    end else if (op >= 4'd1 && op <= 4'd4) begin
      push(w(B_ASA, 2'b10, 2'b00, 3'(4 + op - 1), 0, 0), rnd1(), rnd4(), 0, "exec_i");
      push(w(B_RW, 2'b00, 2'b00, 3'b000, 1, 0), rnd1(), rnd4(), 0, "wb_i");
    end else if (op == 4'd5 || op == 4'd6) begin
      push(w(B_ASA, 2'b10, 2'b00, 3'b100, 0, 0), rnd1(), rnd4(), 0, "mem_addr");
      if (op == 4'd5) begin
        for (int i = 0; i < wm; i++)
          push(w(B_MR | B_IORD, 2'b00, 2'b00, 3'b000, 0, 0), 1'b0, rnd4(), 1, "mem_rd_wait");
        push(w(B_MR | B_IORD, 2'b00, 2'b00, 3'b000, 0, 0), 1'b1, rnd4(), 0, "mem_rd");
        push(w(B_RW | B_M2R, 2'b00, 2'b00, 3'b000, 1, 0), rnd1(), rnd4(), 0, "mem_wb");
      end else begin
        for (int i = 0; i < wm; i++)
          push(w(B_MW | B_IORD, 2'b00, 2'b00, 3'b000, 0, 0), 1'b0, rnd4(), 1, "mem_wr_wait");
        push(w(B_MW | B_IORD, 2'b00, 2'b00, 3'b000, 1, 0), 1'b1, rnd4(), 0, "mem_wr");
      end
    end else if (op == 4'd7) begin
      push(w(B_PCW, 2'b00, 2'b10, 3'b000, 1, 0), rnd1(), rnd4(), 0, "jump");
    end else if (op == 4'd8) begin
      push(w(B_PCWC | B_ASA, 2'b00, 2'b01, 3'b101, 1, 0), rnd1(), rnd4(), 0, "branch");
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++)
        push(w(10'd0, 2'b00, 2'b00, 3'b000, 0, 1), rnd1(), rnd4(), 0, "halt");
`endif
    end
    exec_queue(abort_after);
`ifdef ILLEGAL_TRAP_EN
    if (!legal && abort_after < 0) do_reset(2);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = 4'h0;
    bus.zero = 1'b0;
    #1;
    check("rst_at_start", 32'(got_w), 32'd0);
    do_reset(3);

    run_instr(4'd0, 0, 0, -1);          // RTYPE, no waits
    run_instr(4'd5, 0, 2, -1);          // LOAD, two MEM_RD waits
    run_instr(4'd8, 0, 0, -1);          // BEQZ
    run_instr(4'd8, 1, 0, -1);          // BEQZ again
    run_instr(4'd2, 0, 0, -1);          // SUBI
    run_instr(4'd6, 2, 3, -1);          // STORE with waits
    run_instr(4'd7, 0, 0, -1);          // JUMP
    run_instr(4'hF, 0, 0, -1);          // illegal opcode

    run_instr(4'd0, 6, 0, -1);          // timeout rises during FETCH wait
    run_instr(4'd1, 5, 0, 3);           // abort mid-wait with reset
    do_reset(2);
    run_instr(4'd7, 0, 0, -1);
    run_instr(4'd6, 0, 3, 5);           // abort during MEM_WR wait
    do_reset(1);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
`ifdef ILLEGAL_TRAP_EN
      op = 4'($urandom_range(0, 8));
`else
      op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15))
                                       : 4'($urandom_range(0, 8));
`endif
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
